// File: rtl/id_ex_operand_stage.sv
// ID/EX segment: registers decoded fields and feeds forwarded
// operands, opcode and store data into the ALU / EX/MEM segment.
module id_ex_operand_stage #(
    parameter bit FWD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallE,
    input  logic        FlushE,
    input  logic [31:0] PCD,
    input  logic [31:0] RegOut1D,
    input  logic [31:0] RegOut2D,
    input  logic [31:0] ImmD,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  RdD,
    input  logic [3:0]  AluContrlD,
    input  logic        AluSrc1D,
    input  logic [1:0]  AluSrc2D,
    input  logic        RegWriteD,
    input  logic        ValidD,
    input  logic        RegWriteM,
    input  logic [4:0]  RdM,
    input  logic [31:0] AluOutM,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] RegWriteDataW,
    output logic [31:0] Operand1,
    output logic [31:0] Operand2,
    output logic [3:0]  AluContrl,
    output logic [31:0] StoreDataE,
    output logic [31:0] PCE,
    output logic [4:0]  RdE,
    output logic        RegWriteE,
    output logic        ValidE
);

    localparam logic [3:0] ALU_ADD = 4'd3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] regout1;
        logic [31:0] regout2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  aluctrl;
        logic        alusrc1;
        logic [1:0]  alusrc2;
        logic        regwrite;
        logic        valid;
    } id_ex_t;

    id_ex_t e;
    id_ex_t d;
    id_ex_t bubble;
    logic [31:0] fwd1;
    logic [31:0] fwd2;

    always_comb begin
        d          = '0;
        d.pc       = PCD;
        d.regout1  = RegOut1D;
        d.regout2  = RegOut2D;
        d.imm      = ImmD;
        d.rs1      = Rs1D;
        d.rs2      = Rs2D;
        d.rd       = RdD;
        d.aluctrl  = AluContrlD;
        d.alusrc1  = AluSrc1D;
        d.alusrc2  = AluSrc2D;
        d.regwrite = RegWriteD;
        d.valid    = ValidD;
    end

    always_comb begin
        bubble         = '0;
        bubble.aluctrl = ALU_ADD;
    end

    // MEM wins over WB; x0 is never forwarded
    always_comb begin
        fwd1 = e.regout1;
        if (FWD_EN && RegWriteM && RdM == e.rs1 && e.rs1 != 5'd0)
            fwd1 = AluOutM;
        else if (FWD_EN && RegWriteW && RdW == e.rs1 && e.rs1 != 5'd0)
            fwd1 = RegWriteDataW;
    end

    always_comb begin
        fwd2 = e.regout2;
        if (FWD_EN && RegWriteM && RdM == e.rs2 && e.rs2 != 5'd0)
            fwd2 = AluOutM;
        else if (FWD_EN && RegWriteW && RdW == e.rs2 && e.rs2 != 5'd0)
            fwd2 = RegWriteDataW;
    end

    // a stall refreshes the operands so a retiring write is not lost
    always_ff @(posedge clk) begin
        if (rst) begin
            e <= bubble;
        end else if (FlushE) begin
            e <= bubble;
        end else if (StallE) begin
            e.regout1 <= fwd1;
            e.regout2 <= fwd2;
        end else begin
            e <= d;
        end
    end

    always_comb begin
        Operand1 = e.alusrc1 ? e.pc : fwd1;
    end

    always_comb begin
        Operand2 = fwd2;
        unique case (e.alusrc2)
            2'b00: Operand2 = fwd2;
            2'b01: Operand2 = {27'b0, e.rs2};
            2'b10: Operand2 = e.imm;
            2'b11: Operand2 = 32'd4;
        endcase
    end

    assign StoreDataE = fwd2;
    assign AluContrl  = e.aluctrl;
    assign PCE        = e.pc;
    assign RdE        = e.rd;
    assign RegWriteE  = e.regwrite;
    assign ValidE     = e.valid;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage with a scoreboard queue;
// a second instance runs with forwarding disabled on the same inputs.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst, StallE, FlushE;
    logic [31:0] PCD, RegOut1D, RegOut2D, ImmD;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic [3:0]  AluContrlD;
    logic        AluSrc1D;
    logic [1:0]  AluSrc2D;
    logic        RegWriteD, ValidD;
    logic        RegWriteM, RegWriteW;
    logic [4:0]  RdM, RdW;
    logic [31:0] AluOutM, RegWriteDataW;

    logic [31:0] op1, op2, st, pce;
    logic [3:0]  alu;
    logic [4:0]  rde;
    logic        rwe, ve;
    logic [31:0] op1n, op2n, stn, pcen;
    logic [3:0]  alun;
    logic [4:0]  rden;
    logic        rwen, ven;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] op1, op2, st, pce;
        logic [31:0] alu, rd, rw, v;
        logic [31:0] op1n, op2n, stn;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    id_ex_operand_stage #(.FWD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
        .PCD(PCD), .RegOut1D(RegOut1D), .RegOut2D(RegOut2D),
        .ImmD(ImmD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .AluContrlD(AluContrlD), .AluSrc1D(AluSrc1D),
        .AluSrc2D(AluSrc2D), .RegWriteD(RegWriteD), .ValidD(ValidD),
        .RegWriteM(RegWriteM), .RdM(RdM), .AluOutM(AluOutM),
        .RegWriteW(RegWriteW), .RdW(RdW),
        .RegWriteDataW(RegWriteDataW),
        .Operand1(op1), .Operand2(op2), .AluContrl(alu),
        .StoreDataE(st), .PCE(pce), .RdE(rde),
        .RegWriteE(rwe), .ValidE(ve)
    );

    id_ex_operand_stage #(.FWD_EN(1'b0)) dut_nf (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
        .PCD(PCD), .RegOut1D(RegOut1D), .RegOut2D(RegOut2D),
        .ImmD(ImmD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .AluContrlD(AluContrlD), .AluSrc1D(AluSrc1D),
        .AluSrc2D(AluSrc2D), .RegWriteD(RegWriteD), .ValidD(ValidD),
        .RegWriteM(RegWriteM), .RdM(RdM), .AluOutM(AluOutM),
        .RegWriteW(RegWriteW), .RdW(RdW),
        .RegWriteDataW(RegWriteDataW),
        .Operand1(op1n), .Operand2(op2n), .AluContrl(alun),
        .StoreDataE(stn), .PCE(pcen), .RdE(rden),
        .RegWriteE(rwen), .ValidE(ven)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag,
                        input logic [31:0] e1, e2, es, ep,
                        input logic [31:0] ea, er, ew, ev,
                        input logic [31:0] n1, n2, ns);
        exp_t x;
        x.tag = tag;
        x.op1 = e1; x.op2 = e2; x.st = es; x.pce = ep;
        x.alu = ea; x.rd = er; x.rw = ew; x.v = ev;
        x.op1n = n1; x.op2n = n2; x.stn = ns;
        sb.push_back(x);
    endtask

    task automatic cmp(input string tag, input string f,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s.%s: got %h expected %h", tag, f, got, exp);
        end
    endtask

    task automatic check_out();
        exp_t x;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: got empty expected entry");
            return;
        end
        x = sb.pop_front();
        cmp(x.tag, "op1", op1, x.op1);
        cmp(x.tag, "op2", op2, x.op2);
        cmp(x.tag, "store", st, x.st);
        cmp(x.tag, "pce", pce, x.pce);
        cmp(x.tag, "alu", {28'b0, alu}, x.alu);
        cmp(x.tag, "rd", {27'b0, rde}, x.rd);
        cmp(x.tag, "rw", {31'b0, rwe}, x.rw);
        cmp(x.tag, "valid", {31'b0, ve}, x.v);
        cmp(x.tag, "nf_op1", op1n, x.op1n);
        cmp(x.tag, "nf_op2", op2n, x.op2n);
        cmp(x.tag, "nf_store", stn, x.stn);
        cmp(x.tag, "nf_pce", pcen, x.pce);
        cmp(x.tag, "nf_valid", {31'b0, ven}, x.v);
    endtask

    initial begin
        rst = 1; StallE = 0; FlushE = 0;
        PCD = 0; RegOut1D = 0; RegOut2D = 0; ImmD = 0;
        Rs1D = 0; Rs2D = 0; RdD = 0; AluContrlD = 0;
        AluSrc1D = 0; AluSrc2D = 0; RegWriteD = 0; ValidD = 0;
        RegWriteM = 0; RdM = 0; AluOutM = 0;
        RegWriteW = 0; RdW = 0; RegWriteDataW = 0;

        // reset held for two cycles, D side carries junk
        PCD = 32'h44; ValidD = 1; RegWriteD = 1; RdD = 3;
        push("rst1", 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        tick(); check_out();
        push("rst2", 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        tick(); check_out();

        // ADDI x5-based load
        rst = 0;
        PCD = 32'h100; Rs1D = 5; RegOut1D = 7; ImmD = 3;
        Rs2D = 0; RegOut2D = 0; AluSrc1D = 0; AluSrc2D = 2'b10;
        AluContrlD = 4'd3; RdD = 5; RegWriteD = 1; ValidD = 1;
        push("addi", 7, 3, 0, 32'h100, 3, 5, 1, 1, 7, 3, 0);
        tick(); check_out();

        // MEM over WB
        RegWriteM = 1; RdM = 5; AluOutM = 32'h11;
        RegWriteW = 1; RdW = 5; RegWriteDataW = 32'h22;
        push("fwd_mem", 32'h11, 3, 0, 32'h100, 3, 5, 1, 1, 7, 3, 0);
        #1; check_out();

        RegWriteM = 0;
        push("fwd_wb", 32'h22, 3, 0, 32'h100, 3, 5, 1, 1, 7, 3, 0);
        #1; check_out();

        // x0 never forwarded
        PCD = 32'h104; Rs1D = 0; RegOut1D = 32'h77;
        RegWriteM = 1; RdM = 0; RegWriteW = 1; RdW = 0;
        push("fwd_x0", 32'h77, 3, 0, 32'h104, 3, 5, 1, 1,
             32'h77, 3, 0);
        tick(); check_out();

        // stall capture of a WB forward to x6
        RegWriteM = 0; RegWriteW = 0; RdM = 0; RdW = 0;
        PCD = 32'h300; Rs1D = 1; RegOut1D = 32'h10;
        Rs2D = 6; RegOut2D = 1; AluSrc2D = 2'b00;
        AluContrlD = 4'd4; RdD = 7;
        push("st_load", 32'h10, 1, 1, 32'h300, 4, 7, 1, 1,
             32'h10, 1, 1);
        tick(); check_out();

        StallE = 1; RegWriteW = 1; RdW = 6; RegWriteDataW = 32'h55;
        PCD = 32'h999; RdD = 9; AluContrlD = 4'd7;
        push("st_fwd", 32'h10, 32'h55, 32'h55, 32'h300, 4, 7, 1, 1,
             32'h10, 1, 1);
        #1; check_out();

        tick();
        RegWriteW = 0;
        push("st_held1", 32'h10, 32'h55, 32'h55, 32'h300, 4, 7, 1, 1,
             32'h10, 1, 1);
        #1; check_out();

        push("st_held2", 32'h10, 32'h55, 32'h55, 32'h300, 4, 7, 1, 1,
             32'h10, 1, 1);
        tick(); check_out();

        // flush beats stall
        FlushE = 1;
        push("flush", 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        tick(); check_out();

        // operand selects
        FlushE = 0; StallE = 0;
        PCD = 32'h200; AluSrc1D = 1; AluSrc2D = 2'b11;
        Rs1D = 2; RegOut1D = 5; Rs2D = 13; RegOut2D = 32'hAB;
        AluContrlD = 4'd3; RdD = 10; RegWriteD = 1; ValidD = 1;
        push("sel_pc4", 32'h200, 4, 32'hAB, 32'h200, 3, 10, 1, 1,
             32'h200, 4, 32'hAB);
        tick(); check_out();

        AluSrc2D = 2'b01;
        push("sel_shamt", 32'h200, 13, 32'hAB, 32'h200, 3, 10, 1, 1,
             32'h200, 13, 32'hAB);
        tick(); check_out();

        // reset during stall, then first load after stall drops
        StallE = 1; PCD = 32'h400; RdD = 12; AluSrc2D = 2'b10;
        ImmD = 32'h9; AluSrc1D = 0;
        push("stall_hold", 32'h200, 13, 32'hAB, 32'h200, 3, 10, 1, 1,
             32'h200, 13, 32'hAB);
        tick(); check_out();

        rst = 1;
        push("rst_stall", 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        tick(); check_out();

        rst = 0; StallE = 0;
        push("post_stall", 5, 9, 32'hAB, 32'h400, 3, 12, 1, 1,
             5, 9, 32'hAB);
        tick(); check_out();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline segment of the RV32 pipelined core, directly upstream of the ALU. Registers decoded fields from ID, applies MEM/WB forwarding to the register operands, and drives `Operand1`, `Operand2` and `AluContrl` into the ALU. It also supplies the forwarded store data and destination tag to the EX/MEM segment. Stall and flush come from the hazard unit.

## Interface
- `FWD_EN`, default 1: 1 enables MEM/WB forwarding; 0 passes the registered RegOut values unmodified.
- `clk`  in  1: core clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `StallE`  in  1: hold the segment contents.
- `FlushE`  in  1: load a bubble.
- `PCD`  in  32: PC of the instruction in ID.
- `RegOut1D`  in  32: register-file read data for rs1.
- `RegOut2D`  in  32: register-file read data for rs2.
- `ImmD`  in  32: sign-extended immediate.
- `Rs1D`  in  5: source register index rs1.
- `Rs2D`  in  5: source register index rs2.
- `RdD`  in  5: destination register index.
- `AluContrlD`  in  4: ALU opcode, using the Parameters.v encoding.
- `AluSrc1D`  in  1: operand-1 select; 0 = rs1, 1 = PC.
- `AluSrc2D`  in  2: operand-2 select; 00 = rs2, 01 = rs2 index zero-extended (shamt), 10 = imm, 11 = constant 4.
- `RegWriteD`  in  1: instruction writes rd.
- `ValidD`  in  1: ID holds a real instruction.
- `RegWriteM`  in  1: MEM-stage write enable, used for forwarding.
- `RdM`  in  5: MEM-stage destination index.
- `AluOutM`  in  32: MEM-stage result.
- `RegWriteW`  in  1: WB-stage write enable.
- `RdW`  in  5: WB-stage destination index.
- `RegWriteDataW`  in  32: WB-stage result.
- `Operand1`  out  32: ALU operand 1.
- `Operand2`  out  32: ALU operand 2.
- `AluContrl`  out  4: ALU opcode.
- `StoreDataE`  out  32: forwarded rs2 value.
- `PCE`  out  32: PC of the EX instruction.
- `RdE`  out  5: EX destination index.
- `RegWriteE`  out  1: EX write enable.
- `ValidE`  out  1: EX holds a real instruction.

## Operation
- **State.** One register bank E holds: PC, RegOut1, RegOut2, Imm, Rs1, Rs2, Rd, AluContrl, AluSrc1, AluSrc2, RegWrite, Valid.
- **Update priority at each edge:** `rst` > `FlushE` > `StallE` > load.
  - `rst` or `FlushE`: all fields 0; AluContrl = `ADD; RegWrite = 0; Valid = 0.
  - Stall: bank E keeps every field except RegOut1E/RegOut2E. Those two are overwritten with the current forwarded values Fwd1/Fwd2, so a MEM/WB write that retires during a stall is not lost.
  - Load: every field takes its D-side input.
- **Forwarding** (combinational, evaluated in EX). Fwd1 is selected by Rs1E:
  - AluOutM if `RegWriteM` && RdM == Rs1E && Rs1E != 0.
  - Otherwise RegWriteDataW if `RegWriteW` && RdW == Rs1E && Rs1E != 0.
  - Otherwise RegOut1E.
  - MEM has priority over WB. Register x0 is never forwarded.
  - Fwd2 uses the same rules with Rs2E.
  - With `FWD_EN` = 0: Fwd1 = RegOut1E and Fwd2 = RegOut2E.
- **Operand 1:** `Operand1` = AluSrc1E ? PCE : Fwd1.
- **Operand 2:** `Operand2` = 00: Fwd2; 01: {27'b0, Rs2E}; 10: ImmE; 11: 32'd4.
- **Other outputs:** `StoreDataE` = Fwd2. `AluContrl`, `PCE`, `RdE`, `RegWriteE` and `ValidE` come straight from bank E.
- **Load-use hazards** are not detected here; the hazard unit must assert `StallE`/`FlushE`.

## Timing
- ID-to-EX latency is 1 cycle. Forward paths are zero-latency, combinational from the M/W inputs to the outputs.
- Reset values: `Operand1` = 0, `Operand2` = 0 (AluSrc2 = 00 and Fwd2 = RegOut2E = 0, unless a forward hits), `AluContrl` = `ADD, `StoreDataE` = 0, `PCE` = 0, `RdE` = 0, `RegWriteE` = 0, `ValidE` = 0.
- `FlushE` and `StallE` both high: the flush wins and a bubble is loaded.
- `rst` asserted mid-stall: the bubble is loaded on that edge.
- A bubble has RegWriteE = 0, so it never causes a downstream forward.
- Stall held N cycles: the outputs other than the forwarded operands are stable for N+1 cycles. On the first edge after `StallE` falls, the D inputs are loaded.
- RdM == RdW == Rs1E with both write enables high: the MEM value is used.

## Test plan
- **Reset then load.** Hold `rst` 2 cycles, then load PCD = 0x100, ADDI (Rs1D = 5, RegOut1D = 7, ImmD = 3, AluSrc2D = 10). Required: `Operand1` = 7, `Operand2` = 3, `PCE` = 0x100, `ValidE` = 1 after 1 edge. During reset all outputs equal the reset values.
- **Forward priority.** Rs1E = 5, RegOut1E = 7, RegWriteM = 1, RdM = 5, AluOutM = 0x11, RegWriteW = 1, RdW = 5, RegWriteDataW = 0x22. Required: `Operand1` = 0x11. Drop RegWriteM: `Operand1` = 0x22. Set Rs1E = RdM = 0: `Operand1` = RegOut1E.
- **Stall capture.** Stall with Rs2E = 6 and a WB forward of 0x55 to x6 (RegOut2E = 1). Next cycle RegWriteW = 0 with `StallE` still high. Required: `StoreDataE` = 0x55 on both cycles.
- **Flush vs stall.** Assert `FlushE` and `StallE` together. Required after the edge: `RegWriteE` = 0, `ValidE` = 0, `AluContrl` = `ADD, `RdE` = 0.
- **Operand selects.** AluSrc1D = 1 with PCD = 0x200: `Operand1` = 0x200. AluSrc2D = 11: `Operand2` = 4. AluSrc2D = 01 with Rs2D = 13: `Operand2` = 13.
- **FWD_EN = 0.** Repeat the forward-priority scenario. Required: `Operand1` = 7.
